// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter:
//   - FSM state encoding (IDLE/ISSUE/WAIT/RESP) and the matching enum type
//   - operation codes (OP_LD / OP_ST)
//   - lane identifiers (LANE0 / LANE1)
//   - lane_onehot(): lane id -> one-hot lane vector {lane1, lane0}
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OP_LD = 1'b0;
  localparam logic OP_ST = 1'b1;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_ISSUE = ISSUE,
    S_WAIT  = WAIT,
    S_RESP  = RESP
  } arb_state_e;

  function automatic logic [1:0] lane_onehot(input logic lane);
    return (lane == LANE1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles everything between the arbiter, the two issue lanes and the
// memory_unit.
//
// Handshake: a lane presents reqN_valid with isst/addr/wdata; the request is
// transferred in the cycle where reqN_valid && reqN_ready are both high.
// While valid && !ready the request fields must stay stable; valid may be
// dropped before ready, which simply withdraws the request. rspN_valid is a
// one-cycle pulse with no back-pressure; rsp_data carries load data (0 for a
// store acknowledge) and holds its value between pulses.
//
// Modports:
//   slave  - arbiter side (inputs: requests, mem_ldresult)
//   master - lane/memory side (the opposite directions)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_isst;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_isst;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_data;

  logic              mem_isld;
  logic              mem_isst;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_ldresult;

  modport slave (
    input  req0_valid, req0_isst, req0_addr, req0_wdata,
    input  req1_valid, req1_isst, req1_addr, req1_wdata,
    input  mem_ldresult,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    output mem_isld, mem_isst, mem_addr, mem_wdata
  );

  modport master (
    output req0_valid, req0_isst, req0_addr, req0_wdata,
    output req1_valid, req1_isst, req1_addr, req1_wdata,
    output mem_ldresult,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    input  mem_isld, mem_isst, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
// Ports:
//   i_valid[1:0]  - request vector {lane1, lane0}
//   i_last_grant  - lane that won the most recent grant
//   o_grant[1:0]  - one-hot grant (all zero when nothing is valid)
// A lone requester always wins; on a conflict the lane that did not win
// last time is chosen.
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_grant == LANE0) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-ported memory_unit between the two issue lanes. One
// request at a time is granted round-robin, issued to the memory for one
// cycle, and answered with a one-cycle response pulse to the granted lane.
//
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   bus (slave)    - lane requests/responses and memory_unit signals
//   busy           - high whenever the FSM is not in IDLE
//   o_dbg_state    - current FSM state
//   stall0_cnt,    - (MEM_ARB_PERF_EN only) saturating count of cycles with
//   stall1_cnt       reqN_valid && !reqN_ready
//
// Optional feature macro: MEM_ARB_PERF_EN (stall counters and their ports).
//
// Transaction shape:
//   store: IDLE(grant) -> ISSUE -> RESP                    (3 cycles)
//   load : IDLE(grant) -> ISSUE -> WAIT x LD_LAT -> RESP   (3+LD_LAT cycles)
// LD_LAT legal range is 1..3.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output arb_state_e        o_dbg_state
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       stall0_cnt,
  output logic [15:0]       stall1_cnt
`endif
);

  // WAIT is entered with LD_LAT-1 so the capture edge lands LD_LAT cycles
  // after the ISSUE cycle.
  localparam logic [1:0] LAT_INIT = 2'(LD_LAT - 1);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic              r_last_grant;
  logic              r_lane;
  logic              r_isst;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_data;
  logic [1:0]        r_lat_cnt;

  logic [1:0]        w_valid;
  logic [1:0]        w_grant;
  logic [1:0]        w_ready;
  logic              w_take;

  assign w_valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_rr_arb2 (
    .i_valid      (w_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // rst_n gates the grant so ready stays low while reset is held even if a
  // lane keeps its request up.
  assign w_take  = rst_n && (r_state == S_IDLE) && (w_valid != 2'b00);
  assign w_ready = w_take ? w_grant : 2'b00;

  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];
  assign bus.rsp_data   = r_rsp_data;
  assign busy           = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;

  // Next state and memory/response strobes.
  always_comb begin
    w_next_state   = r_state;
    bus.mem_isld   = 1'b0;
    bus.mem_isst   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        if (r_isst == OP_ST) begin
          bus.mem_isst = 1'b1;
          w_next_state = S_RESP;
        end else begin
          bus.mem_isld = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == 2'd0) w_next_state = S_RESP;
      end
      S_RESP: begin
        {bus.rsp1_valid, bus.rsp0_valid} = lane_onehot(r_lane);
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture registers, round-robin history, latency counter, response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= LANE1;
      r_lane       <= LANE0;
      r_isst       <= OP_LD;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_lat_cnt    <= 2'd0;
      r_rsp_data   <= '0;
    end else begin
      if (w_take) begin
        r_lane       <= w_grant[1];
        r_last_grant <= w_grant[1];
        if (w_grant[1]) begin
          r_isst  <= bus.req1_isst;
          r_addr  <= bus.req1_addr;
          r_wdata <= bus.req1_wdata;
        end else begin
          r_isst  <= bus.req0_isst;
          r_addr  <= bus.req0_addr;
          r_wdata <= bus.req0_wdata;
        end
      end

      // rsp_data only changes on the edge into RESP, so it holds between
      // response pulses: zero for a store ack, captured data for a load.
      if (r_state == S_ISSUE) begin
        if (r_isst == OP_ST) r_rsp_data <= '0;
        else                 r_lat_cnt  <= LAT_INIT;
      end

      if (r_state == S_WAIT) begin
        if (r_lat_cnt == 2'd0) r_rsp_data <= bus.mem_ldresult;
        else                   r_lat_cnt  <= r_lat_cnt - 2'd1;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0] r_stall0_cnt;
  logic [15:0] r_stall1_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall0_cnt <= 16'd0;
      r_stall1_cnt <= 16'd0;
    end else begin
      if (bus.req0_valid && !w_ready[0] && (r_stall0_cnt != 16'hFFFF))
        r_stall0_cnt <= r_stall0_cnt + 16'd1;
      if (bus.req1_valid && !w_ready[1] && (r_stall1_cnt != 16'hFFFF))
        r_stall1_cnt <= r_stall1_cnt + 16'd1;
    end
  end

  assign stall0_cnt = r_stall0_cnt;
  assign stall1_cnt = r_stall1_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Bench for mem_port_arbiter (LD_LAT = 2). Lanes are driven from per-lane
// request queues (directed) or at random; a memory_unit stand-in answers
// loads exactly LD_LAT cycles after the issue cycle and returns junk
// otherwise. The reference model tracks one transaction at a time by cycle
// number (grant cycle, issue = grant+1, response = grant+2(+LD_LAT)).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int LD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  logic       busy;
  arb_state_e dbg_state;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] stall0_cnt;
  logic [15:0] stall1_cnt;
`endif

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LD_LAT(LD_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .o_dbg_state (dbg_state)
`ifdef MEM_ARB_PERF_EN
    ,
    .stall0_cnt  (stall0_cnt),
    .stall1_cnt  (stall1_cnt)
`endif
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic        v[2];
  logic        st[2];
  logic [15:0] a[2];
  logic [15:0] d[2];
  bit          acc[2];
  logic [32:0] dq0[$];
  logic [32:0] dq1[$];
  bit          rnd_en;
  bit          rel_rst;

  // reference model
  bit          inflight;
  int          g_cyc;
  int          rsp_cyc;
  logic        cur_lane;
  logic        cur_st;
  logic [15:0] cur_addr;
  logic [15:0] cur_wdata;
  logic        last_grant;
  logic [15:0] last_rsp;
  logic [15:0] exp_q[$];
  logic [15:0] ref_mem[logic [15:0]];
  int          stall_m[2];

  // memory_unit stand-in
  logic [15:0] emu_mem[logic [15:0]];
  bit          ld_pending;
  int          ld_cyc;
  logic [15:0] ld_addr;

  // observations of the DUT for directed checks
  int          dut_grants[$];
  int          rsp0_seen;
  logic [15:0] last_rsp0_data;
  logic [15:0] last_rsp1_data;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight   = 1'b0;
    last_grant = LANE1;
    last_rsp   = 16'h0000;
    exp_q.delete();
    stall_m[0] = 0;
    stall_m[1] = 0;
    ld_pending = 1'b0;
  endtask

  task automatic push_req(input int lane, input logic s, input logic [15:0] ad, input logic [15:0] da);
    if (lane == 0) dq0.push_back({s, ad, da});
    else           dq1.push_back({s, ad, da});
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    if (rel_rst) begin
      rst_n   = 1'b1;
      rel_rst = 1'b0;
    end
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) begin
        v[n]   = 1'b0;
        acc[n] = 1'b0;
      end
      if (rnd_en && v[n] && $urandom_range(0, 15) == 0) v[n] = 1'b0;
      if (!v[n]) begin
        if (n == 0 && dq0.size() > 0) begin
          {st[0], a[0], d[0]} = dq0.pop_front();
          v[0] = 1'b1;
        end else if (n == 1 && dq1.size() > 0) begin
          {st[1], a[1], d[1]} = dq1.pop_front();
          v[1] = 1'b1;
        end else if (rnd_en && $urandom_range(0, 2) == 0) begin
          st[n] = 1'($urandom_range(0, 1));
          a[n]  = 16'($urandom_range(0, 7));
          d[n]  = 16'($urandom);
          v[n]  = 1'b1;
        end
      end
    end
    bus.req0_valid = v[0];
    bus.req0_isst  = st[0];
    bus.req0_addr  = a[0];
    bus.req0_wdata = d[0];
    bus.req1_valid = v[1];
    bus.req1_isst  = st[1];
    bus.req1_addr  = a[1];
    bus.req1_wdata = d[1];
    if (ld_pending && cyc > ld_cyc + LD_LAT) ld_pending = 1'b0;
    if (ld_pending && cyc == ld_cyc + LD_LAT)
      bus.mem_ldresult = emu_mem.exists(ld_addr) ? emu_mem[ld_addr] : 16'h0000;
    else
      bus.mem_ldresult = 16'($urandom);
  endtask

  // ---------------- per-cycle check (at negedge) ----------------
  task automatic check_cycle();
    bit          in_idle, any, win, er0, er1, is_issue, is_rsp;
    logic [1:0]  exp_state;
    logic [15:0] exp_data;
    if (!rst_n) begin
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_rsp0", bus.rsp0_valid, 0);
      chk("rst_rsp1", bus.rsp1_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_isld", bus.mem_isld, 0);
      chk("rst_isst", bus.mem_isst, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", dbg_state, IDLE);
`ifdef MEM_ARB_PERF_EN
      chk("rst_stall0", stall0_cnt, 0);
      chk("rst_stall1", stall1_cnt, 0);
`endif
      return;
    end

    in_idle  = !inflight;
    any      = v[0] || v[1];
    win      = (v[0] && v[1]) ? !last_grant : v[1];
    er0      = in_idle && any && !win;
    er1      = in_idle && any && win;
    is_issue = inflight && (cyc == g_cyc + 1);
    is_rsp   = inflight && (cyc == rsp_cyc);
    exp_state = !inflight ? IDLE : is_issue ? ISSUE : is_rsp ? RESP : WAIT;
    exp_data  = is_rsp ? ((exp_q.size() > 0) ? exp_q[0] : 16'h0000) : last_rsp;

    chk("ready0", bus.req0_ready, er0);
    chk("ready1", bus.req1_ready, er1);
    chk("busy", busy, inflight);
    chk("state", dbg_state, exp_state);
    chk("mem_isld", bus.mem_isld, is_issue && !cur_st);
    chk("mem_isst", bus.mem_isst, is_issue && cur_st);
    chk("mem_addr", bus.mem_addr, is_issue ? cur_addr : 16'h0000);
    chk("mem_wdata", bus.mem_wdata, is_issue ? cur_wdata : 16'h0000);
    chk("rsp0_valid", bus.rsp0_valid, is_rsp && cur_lane == LANE0);
    chk("rsp1_valid", bus.rsp1_valid, is_rsp && cur_lane == LANE1);
    chk("rsp_data", bus.rsp_data, exp_data);
`ifdef MEM_ARB_PERF_EN
    chk("stall0", stall0_cnt, stall_m[0]);
    chk("stall1", stall1_cnt, stall_m[1]);
`endif

    // DUT observations
    if (bus.req0_ready && v[0]) dut_grants.push_back(0);
    if (bus.req1_ready && v[1]) dut_grants.push_back(1);
    if (bus.rsp0_valid) begin rsp0_seen++; last_rsp0_data = bus.rsp_data; end
    if (bus.rsp1_valid) last_rsp1_data = bus.rsp_data;

    // memory_unit stand-in follows what the DUT actually issues
    if (bus.mem_isst) emu_mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_isld) begin
      ld_pending = 1'b1;
      ld_cyc     = cyc;
      ld_addr    = bus.mem_addr;
    end

    // model update
    if (v[0] && !er0 && stall_m[0] < 65535) stall_m[0]++;
    if (v[1] && !er1 && stall_m[1] < 65535) stall_m[1]++;
    if (is_rsp) begin
      last_rsp = exp_q.pop_front();
      inflight = 1'b0;
    end
    if (er0 || er1) begin
      inflight   = 1'b1;
      g_cyc      = cyc;
      cur_lane   = win;
      cur_st     = st[win];
      cur_addr   = a[win];
      cur_wdata  = d[win];
      rsp_cyc    = cyc + 2 + (st[win] ? 0 : LD_LAT);
      last_grant = win;
      if (st[win]) begin
        ref_mem[a[win]] = d[win];
        exp_q.push_back(16'h0000);
      end else begin
        exp_q.push_back(ref_mem.exists(a[win]) ? ref_mem[a[win]] : 16'h0000);
      end
      acc[win] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_idle(input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((inflight || v[0] || v[1] || dq0.size() > 0 || dq1.size() > 0) && k < 300);
    chk({tag, "_done"}, k < 300, 1);
    step();
  endtask

  // Asynchronous reset asserted mid-cycle, held for two cycles.
  task automatic reset_pulse();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_isld", bus.mem_isld, 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_rsp0", bus.rsp0_valid, 0);
    chk("arst_rsp_data", bus.rsp_data, 0);
    chk("arst_state", dbg_state, IDLE);
    model_reset();
    rsp0_seen = 0;
    @(negedge clk);
    check_cycle();
    step();
    rel_rst = 1'b1;
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    rst_n   = 1'b0;
    rnd_en  = 1'b0;
    rel_rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; st[n] = 1'b0; a[n] = 16'h0; d[n] = 16'h0; acc[n] = 1'b0;
    end
    last_rsp0_data = 16'hFFFF;
    last_rsp1_data = 16'hFFFF;
    rsp0_seen = 0;
    model_reset();
    bus.mem_ldresult = 16'h0;
    repeat (3) step();
    rel_rst = 1'b1;
    step();

    // lane 0 store, then lane 1 load of the same word
    push_req(0, OP_ST, 16'h0001, 16'hA5A5);
    run_idle("st0");
    chk("st0_ack_data", last_rsp0_data, 16'h0000);
    push_req(1, OP_LD, 16'h0001, 16'h1234);
    run_idle("ld1");
    chk("ld1_data", last_rsp1_data, 16'hA5A5);

    // conflict straight out of reset: lane 0 first
    reset_pulse();
    dut_grants.delete();
    push_req(0, OP_ST, 16'h0003, 16'h100A);
    push_req(1, OP_LD, 16'h0003, 16'h0000);
    run_idle("conf");
    chk("conf_n", dut_grants.size(), 2);
    chk("conf_g0", (dut_grants.size() > 0) ? dut_grants[0] : 9, 0);
    chk("conf_g1", (dut_grants.size() > 1) ? dut_grants[1] : 9, 1);
    chk("conf_data", last_rsp1_data, 16'h100A);

    // lane 1 stalls behind a lane 0 load (both valid from reset)
    reset_pulse();
    push_req(0, OP_LD, 16'h0003, 16'h0000);
    push_req(1, OP_LD, 16'h0001, 16'h0000);
    k = 0;
    do begin step(); k++; end while (!bus.req1_ready && k < 30);
    chk("stall_wait", k < 30, 1);
`ifdef MEM_ARB_PERF_EN
    chk("stall1_at_grant", stall1_cnt, 5);
`endif
    run_idle("stall");

    // both lanes continuously valid: grants alternate
    dut_grants.delete();
    for (int i = 0; i < 3; i++) begin
      push_req(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom));
      push_req(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom));
    end
    run_idle("alt");
    chk("alt_n", dut_grants.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("alt_grant", (i < dut_grants.size()) ? dut_grants[i] : 9, i % 2);

    // reset during WAIT of a lane 0 load
    push_req(0, OP_LD, 16'h0001, 16'h0000);
    k = 0;
    do begin step(); k++; end
    while (!(inflight && cur_lane == LANE0 && !cur_st && cyc == g_cyc + 1) && k < 30);
    chk("wait_reach", k < 30, 1);
    reset_pulse();
    repeat (8) step();
    chk("no_rsp0_after_rst", rsp0_seen, 0);
    dut_grants.delete();
    push_req(0, OP_ST, 16'h0005, 16'h5A5A);
    push_req(1, OP_ST, 16'h0006, 16'h6B6B);
    run_idle("post_rst");
    chk("post_rst_grant", (dut_grants.size() > 0) ? dut_grants[0] : 9, 0);

    // random traffic
    rnd_en = 1'b1;
    repeat (2500) step();
    rnd_en = 1'b0;
    run_idle("drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported memory_unit between the two issue lanes of the superscalar core.
- Accepts load/store requests from lane 0 and lane 1 with valid/ready handshakes.
- Picks one requester round-robin and sequences it onto the memory_unit control, address and data inputs (isld, isst, aluresult, op2).
- Returns load data (or a store acknowledge) to the granted lane as a one-cycle response pulse.

Parameters:
- DATA_W, 16, width of store data and load result.
- ADDR_W, 16, width of memory address (drives memory_unit aluresult).
- LD_LAT, 1, cycles from the memory issue cycle until mem_ldresult is valid; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req0_valid  in  1  lane 0 request present.
- req0_ready  out  1  lane 0 request accepted this cycle.
- req0_isst  in  1  lane 0 op: 1 = store, 0 = load.
- req0_addr  in  ADDR_W  lane 0 address.
- req0_wdata  in  DATA_W  lane 0 store data.
- req1_valid, req1_ready, req1_isst, req1_addr, req1_wdata: same as lane 0, for lane 1.
- rsp0_valid  out  1  one-cycle response pulse to lane 0.
- rsp1_valid  out  1  one-cycle response pulse to lane 1.
- rsp_data  out  DATA_W  load data; 0 for store acknowledges.
- mem_isld  out  1  to memory_unit isld.
- mem_isst  out  1  to memory_unit isst.
- mem_addr  out  ADDR_W  to memory_unit aluresult.
- mem_wdata  out  DATA_W  to memory_unit op2.
- mem_ldresult  in  DATA_W  from memory_unit ldresult.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; last_grant=1, so lane 0 wins the first conflict; latency counter=0.
  - All outputs 0: req*_ready, rsp*_valid, rsp_data, mem_isld, mem_isst, mem_addr, mem_wdata, busy.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any reqN_valid, select a winner; reqN_ready=1 (combinational) for the winner only, in this cycle only.
  - Capture the winner's isst/addr/wdata and lane id; go to ISSUE.
  - req*_ready is 0 in every other state.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the lane != last_grant.
  - last_grant updates only on a grant.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata driven from the captured request.
  - mem_isst=1 for a store, mem_isld=1 for a load; never both.
  - Store: go to RESP. Load: go to WAIT with counter=LD_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, register mem_ldresult into rsp_data and go to RESP.
  - Latency from ISSUE to data capture is LD_LAT cycles.
- RESP (1 cycle):
  - rspN_valid=1 for the captured lane, then go to IDLE.
  - Store acknowledges have rsp_data=0.
- Outside ISSUE: mem_isld and mem_isst are 0; mem_addr and mem_wdata are driven to 0.
- Occupancy:
  - Store: IDLE, ISSUE, RESP = 3 cycles.
  - Load: 3+LD_LAT cycles.
  - A new grant is possible in the IDLE cycle following RESP.
- Requester rules:
  - reqN fields must be held stable while valid && !ready.
  - Dropping valid before ready is legal; no grant is issued for that lane.
- rsp_data holds its last value when no rsp is valid.
- Reset mid-transaction: the in-flight access is abandoned and no response is issued. A store already issued in ISSUE has completed in memory.

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - Adds output ports stall0_cnt and stall1_cnt, 16 bits each.
  - Each increments, saturating at 16'hFFFF, on every cycle with reqN_valid && !reqN_ready.
  - Both cleared by rst_n.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - OP_LD=1'b0 / OP_ST=1'b1;
  - LANE0=1'b0 / LANE1=1'b1.
- One sub-module, rr_arb2: a combinational 2-way round-robin picker taking valid[1:0] and last_grant, producing a one-hot grant. The FSM, capture registers and latency counter stay in mem_port_arbiter.

Test Plan:
- Store from lane 0 only, addr=16'h0001, wdata=16'hA5A5:
  - req0_ready pulses in the first cycle;
  - next cycle mem_isst=1, mem_addr=16'h0001, mem_wdata=16'hA5A5;
  - next cycle rsp0_valid=1, rsp_data=0.
- Load from lane 1, addr=16'h0001, after that store, LD_LAT=1: mem_isld=1 for one cycle, then RESP with rsp1_valid=1, rsp_data=16'hA5A5.
- Both lanes valid from reset (lane 0 store to 16'h0003 with 16'h100A; lane 1 load from 16'h0003):
  - lane 0 granted first, lane 1 granted in the IDLE cycle after lane 0's RESP;
  - lane 1 receives rsp_data=16'h100A.
- Both lanes continuously valid for 6 grants: grants alternate 0,1,0,1,0,1, and no lane is ever starved.
- rst_n pulled low during WAIT of a lane 0 load: all outputs 0 immediately, no rsp0_valid afterwards, and the next conflict is granted to lane 0.
- With MEM_ARB_PERF_EN, lane 1 held valid during a lane 0 load with LD_LAT=2: stall1_cnt=5 by the time req1_ready asserts.
